mc_ctrl: RTL

Multi-cycle main controller for the MIPS32 core. It decodes the instruction held in the IR and steps the datapath through FETCH / DECODE / EXE / MEM / WB. Each cycle it drives the write enables and the mux selects for PC, IR, register file, data memory, ALU and immediate extender (EOp). It also counts retired instructions and flags unsupported opcodes.

---
 rtl/mc_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Purpose  : Multi-cycle MIPS32 main controller (FETCH/DECODE/EXE/MEM/WB).
// Revision : 1.0
// ============================================================================
module mc_ctrl #(
    parameter logic [4:0] RA_REG = 5'd31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        dm_rdy,
    output logic        PCWr,
    output logic        IRWr,
    output logic        RFWr,
    output logic        DMWr,
    output logic [1:0]  NPCOp,
    output logic [1:0]  EOp,
    output logic [1:0]  ALUOp,
    output logic        ALUSrc,
    output logic [1:0]  RegDst,
    output logic [1:0]  WDSel,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t cur_state;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       is_rtype, is_addu, is_subu, is_jr, is_ori, is_lw, is_sw;
    logic       is_beq, is_lui, is_j, is_jal, is_legal, in_instr;

    // RA_REG is applied by the datapath's RegDst mux; only the opcode/funct fields matter here.
    logic unused_bits;
    assign unused_bits = &{1'b0, instr[25:6], RA_REG};

    assign opcode   = instr[31:26];
    assign funct    = instr[5:0];
    assign is_rtype = (opcode == 6'b000000);
    assign is_addu  = is_rtype && (funct == 6'b100001);
    assign is_subu  = is_rtype && (funct == 6'b100011);
    assign is_jr    = is_rtype && (funct == 6'b001000);
    assign is_ori   = (opcode == 6'b001101);
    assign is_lw    = (opcode == 6'b100011);
    assign is_sw    = (opcode == 6'b101011);
    assign is_beq   = (opcode == 6'b000100);
    assign is_lui   = (opcode == 6'b001111);
    assign is_j     = (opcode == 6'b000010);
    assign is_jal   = (opcode == 6'b000011);
    assign is_legal = is_addu | is_subu | is_jr | is_ori | is_lw | is_sw |
                      is_beq | is_lui | is_j | is_jal;

    assign in_instr = (cur_state == S_DECODE) || (cur_state == S_EXE) ||
                      (cur_state == S_MEM)    || (cur_state == S_WB);
    assign state    = cur_state;

    // Selects depend only on the held instruction so they stay constant from DECODE to WB.
    always_comb begin
        NPCOp  = 2'b00;
        EOp    = 2'b00;
        ALUOp  = 2'b00;
        ALUSrc = 1'b0;
        RegDst = 2'b00;
        WDSel  = 2'b00;
        if (in_instr) begin
            if (is_addu) RegDst = 2'b01;
            if (is_subu) begin ALUOp = 2'b01; RegDst = 2'b01; end
            if (is_jr)   NPCOp = 2'b11;
            if (is_ori)  begin EOp = 2'b01; ALUSrc = 1'b1; ALUOp = 2'b10; end
            if (is_lui)  begin EOp = 2'b10; ALUSrc = 1'b1; ALUOp = 2'b10; end
            if (is_lw)   begin ALUSrc = 1'b1; WDSel = 2'b01; end
            if (is_sw)   ALUSrc = 1'b1;
            if (is_beq)  begin ALUOp = 2'b01; EOp = 2'b11; NPCOp = 2'b01; end
            if (is_j)    NPCOp = 2'b10;
            if (is_jal)  begin NPCOp = 2'b10; RegDst = 2'b10; WDSel = 2'b10; end
        end
    end

    // Write enables are gated by rst_n so they drop the instant reset asserts.
    always_comb begin
        PCWr    = 1'b0;
        IRWr    = 1'b0;
        RFWr    = 1'b0;
        DMWr    = 1'b0;
        illegal = 1'b0;
        case (cur_state)
            S_FETCH:  begin PCWr = 1'b1; IRWr = 1'b1; end
            S_DECODE: begin
                PCWr    = is_j | is_jal | is_jr;
                RFWr    = is_jal;
                illegal = ~is_legal;
            end
            S_EXE:    PCWr = is_beq & zero;
            S_MEM:    DMWr = is_sw;
            S_WB:     RFWr = 1'b1;
            default:  ;
        endcase
        PCWr = PCWr & rst_n;
        IRWr = IRWr & rst_n;
        RFWr = RFWr & rst_n;
        DMWr = DMWr & rst_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_FETCH;
            retired   <= 32'd0;
        end else begin
            case (cur_state)
                S_FETCH:  cur_state <= S_DECODE;
                S_DECODE: begin
                    if (is_j || is_jal || is_jr) begin
                        cur_state <= S_FETCH;
                        retired   <= retired + 32'd1;
                    end else if (!is_legal) begin
                        cur_state <= S_FETCH;
                    end else begin
                        cur_state <= S_EXE;
                    end
                end
                S_EXE: begin
                    if (is_beq) begin
                        cur_state <= S_FETCH;
                        retired   <= retired + 32'd1;
                    end else if (is_lw || is_sw) begin
                        cur_state <= S_MEM;
                    end else begin
                        cur_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dm_rdy) begin
                        if (is_lw) begin
                            cur_state <= S_WB;
                        end else begin
                            cur_state <= S_FETCH;
                            if (is_sw) retired <= retired + 32'd1;
                        end
                    end
                end
                S_WB: begin
                    cur_state <= S_FETCH;
                    retired   <= retired + 32'd1;
                end
                default: cur_state <= S_FETCH;
            endcase
        end
    end

endmodule
`default_nettype wire
